// File: rtl/stq_fwd_if.sv
// Store-queue port bundle: dispatch, issue, load lookup, retire/flush and Dcache drain.
interface stq_fwd_if #(
  parameter int unsigned STQ_IDX = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64
);
  logic [1:0]         disp_cnt;
  logic [STQ_IDX-1:0] disp_idx0;
  logic [STQ_IDX-1:0] disp_idx1;
  logic [1:0]         disp_ok;
  logic               iss_valid;
  logic [STQ_IDX-1:0] iss_idx;
  logic [ADDR_W-1:0]  iss_addr;
  logic [DATA_W-1:0]  iss_data;
  logic               ld_valid;
  logic [STQ_IDX-1:0] ld_age;
  logic               ld_old;
  logic [ADDR_W-1:0]  ld_addr;
  logic               ld_hit;
  logic [DATA_W-1:0]  ld_data;
  logic               ld_stall;
  logic [1:0]         retire_cnt;
  logic               flush;
  logic               dc_req;
  logic [ADDR_W-1:0]  dc_addr;
  logic [DATA_W-1:0]  dc_data;
  logic               dc_gnt;
  logic [STQ_IDX:0]   count;
  logic               empty;

  modport master (
    output disp_cnt, iss_valid, iss_idx, iss_addr, iss_data,
           ld_valid, ld_age, ld_old, ld_addr, retire_cnt, flush, dc_gnt,
    input  disp_idx0, disp_idx1, disp_ok, ld_hit, ld_data, ld_stall,
           dc_req, dc_addr, dc_data, count, empty
  );

  modport slave (
    input  disp_cnt, iss_valid, iss_idx, iss_addr, iss_data,
           ld_valid, ld_age, ld_old, ld_addr, retire_cnt, flush, dc_gnt,
    output disp_idx0, disp_idx1, disp_ok, ld_hit, ld_data, ld_stall,
           dc_req, dc_addr, dc_data, count, empty
  );
endinterface

// File: rtl/stq_fwd.sv
// Store queue: dual dispatch, issue-time fill, youngest-match load forwarding,
// commit pointer from ROB retire, flush of uncommitted entries, req/gnt drain.
module stq_fwd #(
  parameter int unsigned STQ_DEPTH = 16,
  parameter int unsigned STQ_IDX   = 4,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64
) (
  input logic      clock,
  input logic      reset,
  stq_fwd_if.slave bus
);
  localparam logic [STQ_IDX:0] DEPTH_W = (STQ_IDX+1)'(STQ_DEPTH);

  logic [STQ_IDX:0]   r_head, r_commit, r_tail;
  logic [ADDR_W-1:0]  r_addr [STQ_DEPTH];
  logic [DATA_W-1:0]  r_data [STQ_DEPTH];
  logic [STQ_DEPTH-1:0] r_rdy;

  logic [STQ_IDX-1:0] w_head_i, w_len, w_e;
  logic [STQ_IDX:0]   w_count, w_free, w_avail, w_commit_n;
  logic [1:0]         w_disp_ok, w_ret, w_alloc;
  logic               w_dc_req, w_drain, w_iss_ok;
  logic [STQ_DEPTH-1:0] w_rdy_n;
  logic               w_f_stall, w_f_hit, w_ld_hit;
  logic [DATA_W-1:0]  w_f_data;

  // Entry i is in [lo, hi) when its distance from lo is below the span length.
  function automatic logic in_rng(input logic [STQ_IDX-1:0] i,
                                  input logic [STQ_IDX:0] lo, input logic [STQ_IDX:0] hi);
    logic [STQ_IDX:0] offs;
    offs = {1'b0, i - lo[STQ_IDX-1:0]};
    return offs < (hi - lo);
  endfunction

  assign w_head_i = r_head[STQ_IDX-1:0];

  always_comb begin
    w_count    = r_tail - r_head;
    w_free     = DEPTH_W - w_count;
    w_disp_ok  = (w_free >= (STQ_IDX+1)'(2)) ? 2'd2 : w_free[1:0];
    w_dc_req   = (r_head != r_commit) && r_rdy[w_head_i];
    w_drain    = w_dc_req && bus.dc_gnt;
    w_avail    = r_tail - r_commit;
    w_ret      = ((STQ_IDX+1)'(bus.retire_cnt) > w_avail) ? w_avail[1:0] : bus.retire_cnt;
    w_commit_n = r_commit + (STQ_IDX+1)'(w_ret);
    w_alloc    = bus.flush ? 2'd0 : ((bus.disp_cnt > w_disp_ok) ? w_disp_ok : bus.disp_cnt);
    w_iss_ok   = bus.iss_valid && !bus.flush && in_rng(bus.iss_idx, r_commit, r_tail);
  end

  always_comb begin
    w_rdy_n = r_rdy;
    if (w_drain) w_rdy_n[w_head_i] = 1'b0;
    for (int unsigned i = 0; i < STQ_DEPTH; i++)
      if (bus.flush && in_rng(STQ_IDX'(i), w_commit_n, r_tail)) w_rdy_n[STQ_IDX'(i)] = 1'b0;
    for (int unsigned k = 0; k < 2; k++)
      if (k < 32'(w_alloc)) w_rdy_n[r_tail[STQ_IDX-1:0] + STQ_IDX'(k)] = 1'b0;
    if (w_iss_ok) w_rdy_n[bus.iss_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head   <= '0;
      r_commit <= '0;
      r_tail   <= '0;
      r_rdy    <= '0;
    end else begin
      if (w_drain) r_head <= r_head + 1'b1;
      r_commit <= w_commit_n;
      r_tail   <= bus.flush ? w_commit_n : r_tail + (STQ_IDX+1)'(w_alloc);
      r_rdy    <= w_rdy_n;
    end
  end

  always_ff @(posedge clock) begin
    if (w_iss_ok) begin
      r_addr[bus.iss_idx] <= bus.iss_addr;
      r_data[bus.iss_idx] <= bus.iss_data;
    end
  end

  // Walk oldest to youngest from head so the last match seen is the youngest one.
  always_comb begin
    w_len     = bus.ld_age - w_head_i;
    w_f_stall = 1'b0;
    w_f_hit   = 1'b0;
    w_f_data  = '0;
    w_e       = '0;
    for (int unsigned k = 0; k < STQ_DEPTH; k++) begin
      w_e = w_head_i + STQ_IDX'(k);
      if (STQ_IDX'(k) < w_len) begin
        if (!r_rdy[w_e]) begin
          w_f_stall = 1'b1;
        end else if (r_addr[w_e] == bus.ld_addr) begin
          w_f_hit  = 1'b1;
          w_f_data = r_data[w_e];
        end
      end
    end
  end

  assign w_ld_hit      = bus.ld_valid && !bus.ld_old && !w_f_stall && w_f_hit;
  assign bus.ld_hit    = w_ld_hit;
  assign bus.ld_stall  = bus.ld_valid && !bus.ld_old && w_f_stall;
  assign bus.ld_data   = w_ld_hit ? w_f_data : '0;
  assign bus.disp_ok   = w_disp_ok;
  assign bus.disp_idx0 = r_tail[STQ_IDX-1:0];
  assign bus.disp_idx1 = r_tail[STQ_IDX-1:0] + 1'b1;
  assign bus.dc_req    = w_dc_req;
  assign bus.dc_addr   = w_dc_req ? r_addr[w_head_i] : '0;
  assign bus.dc_data   = w_dc_req ? r_data[w_head_i] : '0;
  assign bus.count     = w_count;
  assign bus.empty     = (w_count == '0);

  a_disp_legal: assert property (@(posedge clock) disable iff (reset)
    !bus.flush |-> (bus.disp_cnt <= w_disp_ok));
  a_retire_legal: assert property (@(posedge clock) disable iff (reset)
    (STQ_IDX+1)'(bus.retire_cnt) <= w_avail);
endmodule

// File: tb/tb_stq_fwd.sv
// Bench for stq_fwd: directed scenarios plus random traffic checked against a
// sequence-number model of the queue.
module tb_stq_fwd;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stq_fwd_if #(.STQ_IDX(4), .ADDR_W(64), .DATA_W(64)) bus ();

  stq_fwd #(.STQ_DEPTH(16), .STQ_IDX(4), .ADDR_W(64), .DATA_W(64)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Model: absolute store sequence numbers; slot = seq mod DEPTH.
  int m_head, m_commit, m_tail;
  logic [63:0] m_addr [int];
  logic [63:0] m_data [int];
  bit          m_rdy  [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.disp_cnt = 2'd0; bus.iss_valid = 1'b0; bus.iss_idx = '0; bus.iss_addr = '0;
    bus.iss_data = '0; bus.ld_valid = 1'b0; bus.ld_age = '0; bus.ld_old = 1'b0;
    bus.ld_addr = '0; bus.retire_cnt = 2'd0; bus.flush = 1'b0; bus.dc_gnt = 1'b0;
  endtask

  task automatic model_reset();
    m_head = 0; m_commit = 0; m_tail = 0;
    m_addr.delete(); m_data.delete(); m_rdy.delete();
  endtask

  // Compare every output with the model, clock once, advance the model.
  task automatic cycle();
    int cnt, dok, s_iss, ret, ndisp;
    bit e_req, e_stall, e_hit, drain;
    logic [63:0] e_data, e_daddr, e_ddata;
    #1;
    cnt   = m_tail - m_head;
    dok   = (DEPTH - cnt >= 2) ? 2 : DEPTH - cnt;
    e_req = (m_head < m_commit) && m_rdy[m_head];
    e_daddr = e_req ? m_addr[m_head] : 64'h0;
    e_ddata = e_req ? m_data[m_head] : 64'h0;
    e_stall = 0; e_hit = 0; e_data = 0;
    if (bus.ld_valid && !bus.ld_old)
      for (int s = m_head; s < m_head + DEPTH; s++) begin
        if (s % DEPTH == int'(bus.ld_age)) break;
        if (!m_rdy[s]) e_stall = 1;
        else if (m_addr[s] == bus.ld_addr) begin e_hit = 1; e_data = m_data[s]; end
      end
    if (e_stall) begin e_hit = 0; e_data = 0; end
    if (!e_hit) e_data = 0;
    chk("count",     64'(bus.count),     64'(cnt));
    chk("empty",     64'(bus.empty),     64'(cnt == 0));
    chk("disp_ok",   64'(bus.disp_ok),   64'(dok));
    chk("disp_idx0", 64'(bus.disp_idx0), 64'(m_tail % DEPTH));
    chk("disp_idx1", 64'(bus.disp_idx1), 64'((m_tail + 1) % DEPTH));
    chk("dc_req",    64'(bus.dc_req),    64'(e_req));
    chk("dc_addr",   bus.dc_addr,        e_daddr);
    chk("dc_data",   bus.dc_data,        e_ddata);
    chk("ld_stall",  64'(bus.ld_stall),  64'(e_stall));
    chk("ld_hit",    64'(bus.ld_hit),    64'(e_hit));
    chk("ld_data",   bus.ld_data,        e_data);
    s_iss = -1;
    if (bus.iss_valid && !bus.flush)
      for (int s = m_commit; s < m_tail; s++)
        if (s % DEPTH == int'(bus.iss_idx)) s_iss = s;
    drain = e_req && bus.dc_gnt;
    ret   = (int'(bus.retire_cnt) > m_tail - m_commit) ? m_tail - m_commit : int'(bus.retire_cnt);
    ndisp = (int'(bus.disp_cnt) > dok) ? dok : int'(bus.disp_cnt);
    @(posedge clock);
    if (reset) model_reset();
    else begin
      if (s_iss >= 0) begin
        m_addr[s_iss] = bus.iss_addr; m_data[s_iss] = bus.iss_data; m_rdy[s_iss] = 1;
      end
      if (drain) begin m_rdy[m_head] = 0; m_head++; end
      m_commit += ret;
      if (bus.flush) begin
        for (int s = m_commit; s < m_tail; s++) m_rdy[s] = 0;
        m_tail = m_commit;
      end else begin
        for (int k = 0; k < ndisp; k++) m_rdy[m_tail + k] = 0;
        m_tail += ndisp;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    model_reset();
    #1 reset = 1'b0;
  endtask

  task automatic issue(input int idx, input logic [63:0] a, input logic [63:0] d);
    bus.iss_valid = 1'b1; bus.iss_idx = 4'(idx); bus.iss_addr = a; bus.iss_data = d;
  endtask

  initial begin
    int cnt, seq, free;
    idle_inputs();

    // Reset and idle
    do_reset();
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_disp_ok", 64'(bus.disp_ok), 64'd2);
    chk("rst_dc_req", 64'(bus.dc_req), 64'd0);
    chk("rst_idx0", 64'(bus.disp_idx0), 64'd0);
    chk("rst_idx1", 64'(bus.disp_idx1), 64'd1);
    cycle();

    // Youngest-match forwarding
    bus.disp_cnt = 2'd2; cycle(); idle_inputs();
    issue(0, 64'h100, 64'hAA); cycle();
    issue(1, 64'h100, 64'hBB); cycle(); idle_inputs();
    bus.ld_valid = 1'b1; bus.ld_age = 4'd2; bus.ld_addr = 64'h100;
    #1;
    chk("fwd_hit", 64'(bus.ld_hit), 64'd1);
    chk("fwd_data", bus.ld_data, 64'hBB);
    chk("fwd_stall", 64'(bus.ld_stall), 64'd0);
    cycle();
    bus.ld_addr = 64'h108;
    #1;
    chk("miss_hit", 64'(bus.ld_hit), 64'd0);
    chk("miss_stall", 64'(bus.ld_stall), 64'd0);
    cycle();

    // Stall on unknown address, then forward after issue
    do_reset();
    bus.disp_cnt = 2'd1; cycle(); idle_inputs();
    bus.ld_valid = 1'b1; bus.ld_age = 4'd1; bus.ld_addr = 64'h40;
    #1;
    chk("stall_stall", 64'(bus.ld_stall), 64'd1);
    chk("stall_hit", 64'(bus.ld_hit), 64'd0);
    issue(0, 64'h40, 64'h5); cycle();
    bus.iss_valid = 1'b0;
    #1;
    chk("unstall_hit", 64'(bus.ld_hit), 64'd1);
    chk("unstall_data", bus.ld_data, 64'h5);
    cycle(); idle_inputs();

    // Drain handshake with held grant
    do_reset();
    bus.disp_cnt = 2'd1; cycle(); idle_inputs();
    issue(0, 64'h200, 64'h7); cycle(); idle_inputs();
    bus.retire_cnt = 2'd1; cycle(); idle_inputs();
    #1;
    chk("drain_req", 64'(bus.dc_req), 64'd1);
    chk("drain_addr", bus.dc_addr, 64'h200);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_addr", bus.dc_addr, 64'h200);
      chk("hold_data", bus.dc_data, 64'h7);
      chk("hold_count", 64'(bus.count), 64'd1);
    end
    bus.dc_gnt = 1'b1; cycle(); bus.dc_gnt = 1'b0;
    #1;
    chk("post_count", 64'(bus.count), 64'd0);
    chk("post_req", 64'(bus.dc_req), 64'd0);
    cycle();

    // Flush of uncommitted entries
    do_reset();
    bus.disp_cnt = 2'd2; cycle(); cycle(); idle_inputs();
    bus.retire_cnt = 2'd1; cycle(); idle_inputs();
    bus.flush = 1'b1; bus.disp_cnt = 2'd2; cycle(); idle_inputs();
    #1;
    chk("flush_count", 64'(bus.count), 64'd1);
    issue(2, 64'h300, 64'h33); cycle(); idle_inputs();
    bus.disp_cnt = 2'd1;
    #1;
    chk("flush_idx0", 64'(bus.disp_idx0), 64'd1);
    cycle(); idle_inputs();
    bus.ld_valid = 1'b1; bus.ld_age = 4'd2; bus.ld_addr = 64'h300;
    cycle(); idle_inputs();

    // Full queue and wrap-around
    do_reset();
    for (int i = 0; i < 8; i++) begin bus.disp_cnt = 2'd2; cycle(); end
    idle_inputs();
    #1;
    chk("full_disp_ok", 64'(bus.disp_ok), 64'd0);
    chk("full_count", 64'(bus.count), 64'd16);
    for (int i = 0; i < 16; i++) begin issue(i, 64'h1000 + 64'(i), 64'(i)); cycle(); end
    idle_inputs();
    bus.retire_cnt = 2'd2; cycle(); idle_inputs();
    bus.dc_gnt = 1'b1; cycle(); cycle(); idle_inputs();
    #1;
    chk("wrap_disp_ok", 64'(bus.disp_ok), 64'd2);
    bus.disp_cnt = 2'd2;
    #1;
    chk("wrap_idx0", 64'(bus.disp_idx0), 64'd0);
    chk("wrap_idx1", 64'(bus.disp_idx1), 64'd1);
    cycle(); idle_inputs();
    issue(0, 64'h1003, 64'h99); cycle();
    issue(1, 64'h2000, 64'h1); cycle(); idle_inputs();
    bus.ld_valid = 1'b1; bus.ld_age = 4'd1; bus.ld_addr = 64'h1003;
    #1;
    chk("wrap_fwd_hit", 64'(bus.ld_hit), 64'd1);
    chk("wrap_fwd_data", bus.ld_data, 64'h99);
    cycle();
    bus.ld_addr = 64'h100F; cycle();
    bus.ld_addr = 64'h2000; cycle();
    idle_inputs();

    // Random traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      cnt  = m_tail - m_head;
      free = DEPTH - cnt;
      bus.disp_cnt   = 2'($urandom_range(0, (free >= 2) ? 2 : free));
      bus.iss_valid  = ($urandom_range(0, 9) < 7);
      bus.iss_idx    = 4'($urandom_range(0, 15));
      bus.iss_addr   = 64'(8 * $urandom_range(0, 7));
      bus.iss_data   = {$urandom, $urandom};
      bus.retire_cnt = 2'($urandom_range(0, (m_tail - m_commit >= 2) ? 2 : m_tail - m_commit));
      bus.flush      = ($urandom_range(0, 39) == 0);
      bus.dc_gnt     = ($urandom_range(0, 9) < 6);
      bus.ld_valid   = $urandom_range(0, 1) == 1;
      seq            = m_head + int'($urandom_range(0, cnt));
      bus.ld_age     = 4'(seq % DEPTH);
      bus.ld_old     = (cnt == 0);
      bus.ld_addr    = 64'(8 * $urandom_range(0, 7));
      cycle();
    end

    // Reset while a drain may be pending
    idle_inputs();
    bus.dc_gnt = 1'b0;
    reset = 1'b1; cycle();
    reset = 1'b0;
    #1;
    chk("rst_mid_req", 64'(bus.dc_req), 64'd0);
    chk("rst_mid_count", 64'(bus.count), 64'd0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stq_fwd.md
Name: stq_fwd

Overview:
Parametrised store queue with store-to-load forwarding and decoupled commit/drain. It accepts up to two store allocations per cycle at dispatch and captures address and data at issue. It answers one load lookup per cycle against older stores and drains committed stores to the Dcache through a req/gnt handshake. It sits between the RS/issue stage, the ROB retire port and the Dcache, and adds branch-mispredict flush of uncommitted stores.

Parameters:
STQ_DEPTH, 16, number of entries (power of two, >= 4)
STQ_IDX, 4, log2(STQ_DEPTH); width of entry index / age tag
ADDR_W, 64, address width
DATA_W, 64, store data width

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
disp_cnt  in  2  stores dispatched this cycle (0..2)
disp_idx0  out  STQ_IDX  entry index given to first dispatched store (= tail)
disp_idx1  out  STQ_IDX  entry index given to second dispatched store (= tail+1 mod depth)
disp_ok  out  2  free slots available this cycle, min(free,2)
iss_valid  in  1  store issue: write address/data into entry
iss_idx  in  STQ_IDX  entry being filled
iss_addr  in  ADDR_W  effective address
iss_data  in  DATA_W  store data
ld_valid  in  1  load lookup request
ld_age  in  STQ_IDX  tail index sampled when the load was dispatched
ld_old  in  1  queue was empty at load dispatch; no older stores
ld_addr  in  ADDR_W  load address
ld_hit  out  1  forwarded data valid
ld_data  out  DATA_W  forwarded store data
ld_stall  out  1  an older store has unknown address; retry later
retire_cnt  in  2  stores committed by ROB this cycle (0..2)
flush  in  1  mispredict: discard all uncommitted entries
dc_req  out  1  drain request for head entry
dc_addr  out  ADDR_W  head store address
dc_data  out  DATA_W  head store data
dc_gnt  in  1  Dcache accepted drain this cycle
count  out  STQ_IDX+1  occupied entries (head..tail)
empty  out  1  count == 0

Behaviour:
- Three pointers, each STQ_IDX+1 bits with a wrap bit: head (oldest), commit (first uncommitted), tail (next free). Invariant: head <= commit <= tail (modular); count = tail-head; full when count == STQ_DEPTH.
- Per-entry state: addr, data, ready bit.
- Reset: all pointers 0, all ready bits 0. Outputs after reset: dc_req=0, dc_addr=0, dc_data=0, ld_hit=0, ld_stall=0, ld_data=0, count=0, empty=1, disp_ok=2, disp_idx0=0, disp_idx1=1.
- Dispatch: disp_ok is derived from registered state only; slots freed by a drain in the same cycle are not visible until the next cycle. Allocated entries get ready=0; tail += disp_cnt. disp_cnt > disp_ok is illegal: flag with a sim assertion and allocate only disp_ok entries.
- Issue: if iss_idx lies in [commit, tail), write addr/data and set ready=1 at the clock edge. Otherwise ignore the issue (stale after flush).
- Load lookup is combinational, with zero-cycle latency. The range is [head, ld_age), compared with wrap-extended arithmetic. The range is empty when ld_old=1 or ld_age==head.
  - ld_stall=1 if any entry in range has ready=0.
  - Otherwise ld_hit=1 if any entry in range has addr==ld_addr. ld_data then comes from the youngest such entry (closest to ld_age).
  - When ld_valid=0, ld_hit, ld_stall and ld_data are all 0.
  - Issue writes in the same cycle are not visible to the lookup (register-then-read).
- Retire: commit += retire_cnt. retire_cnt greater than (tail-commit) is illegal; assert and clamp.
- Drain:
  - dc_req=1 when head != commit and the head entry is ready. Committed entries are always ready; the ready check is a safety net.
  - dc_addr/dc_data equal the head entry and stay stable while dc_req=1 and dc_gnt=0.
  - On dc_req & dc_gnt: clear the head ready bit; head += 1. Drain is one entry per cycle.
- Flush: tail <= commit (after applying this cycle's retire_cnt). Clear ready bits of discarded entries. Dispatch and issue in the flush cycle are ignored. Drain continues unaffected.
- Simultaneous events, order of evaluation within a cycle: drain, then retire, then flush or dispatch.
- Wrap-around: indices are taken mod STQ_DEPTH; the wrap bit distinguishes full from empty.
- Reset mid-drain: dc_req drops in the cycle after reset is sampled, and any pending entries are lost.

Test Plan:
- Reset, then idle: count=0, empty=1, disp_ok=2, dc_req=0, disp_idx0=0, disp_idx1=1.
- Forwarding picks the youngest match:
  - Stimulus: dispatch 2 stores (idx 0,1); issue idx0 addr=0x100 data=0xAA; issue idx1 addr=0x100 data=0xBB.
  - Load ld_age=2, addr=0x100 -> ld_hit=1, ld_data=0xBB, ld_stall=0.
  - Same load with addr=0x108 -> ld_hit=0, ld_stall=0.
- Stall on unknown address: dispatch 1 store (idx 0), no issue; load ld_age=1, addr=0x40 -> ld_stall=1, ld_hit=0. Issue idx0 addr=0x40 data=0x5 -> next cycle ld_hit=1, ld_data=0x5.
- Drain handshake:
  - Retire 1 committed store (addr=0x200, data=0x7): dc_req=1, dc_addr=0x200.
  - Hold dc_gnt=0 for 3 cycles: outputs stable, count unchanged.
  - dc_gnt=1: count decrements next cycle and dc_req drops.
- Flush: dispatch 4, retire 1, flush -> tail=commit=1, count=1; a late issue to idx 2 is ignored; the next dispatch gets disp_idx0=1.
- Full and wrap: with STQ_DEPTH=16, dispatch 16 -> disp_ok=0. Drain 2 -> disp_ok=2; the next dispatch gets indices 0 and 1 (wrapped). A load with ld_age=1 spans entries 2..15,0 correctly.
